// File: rtl/bcd_timer_ctrl_if.sv
// Command channel for bcd_timer_ctrl: valid/ready handshake carrying an opcode
// and a BCD payload.
//   cmd_valid  command present (master -> slave)
//   cmd        00 START, 01 STOP, 10 CLEAR, 11 LOAD_TARGET
//   cmd_data   BCD target for LOAD_TARGET, digit 0 in bits [3:0]
//   cmd_ready  slave can accept a command this cycle (slave -> master)
interface bcd_timer_ctrl_if #(
    parameter int unsigned DIGITS = 4
);
    localparam int unsigned CW = 4 * DIGITS;

    logic          cmd_valid;
    logic [1:0]    cmd;
    logic [CW-1:0] cmd_data;
    logic          cmd_ready;

    modport master (
        output cmd_valid,
        output cmd,
        output cmd_data,
        input  cmd_ready
    );

    modport slave (
        input  cmd_valid,
        input  cmd,
        input  cmd_data,
        output cmd_ready
    );
endinterface

// File: rtl/bcd_timer_ctrl.sv
// Stopwatch/timer controller: a cascade of DIGITS decimal counters advanced by a
// prescaled tick, driven by START/STOP/CLEAR/LOAD_TARGET commands, with an alarm
// when the count reaches a loadable BCD target.
// Ports:
//   clock     system clock, rising edge
//   reset     asynchronous, active-high
//   cmd_bus   command handshake (slave side)
//   count     current BCD count, digit 0 in bits [3:0]
//   running   high while counting
//   alarm     high once the target has been reached
//   tick      combinational pulse in the cycle digit 0 is enabled
//   overflow  one-cycle pulse after the count wraps all-9 -> all-0
//   err       one-cycle pulse after a LOAD_TARGET carrying a non-BCD digit
module bcd_timer_ctrl #(
    parameter int unsigned DIGITS   = 4,
    parameter int unsigned PRESCALE = 10
) (
    input  logic                  clock,
    input  logic                  reset,
    bcd_timer_ctrl_if.slave       cmd_bus,
    output logic [4*DIGITS-1:0]   count,
    output logic                  running,
    output logic                  alarm,
    output logic                  tick,
    output logic                  overflow,
    output logic                  err
);
    localparam int unsigned CW = 4 * DIGITS;
    localparam int unsigned PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        HOLD = 2'd2,
        DONE = 2'd3
    } state_e;

    typedef enum logic [1:0] {
        CMD_START = 2'b00,
        CMD_STOP  = 2'b01,
        CMD_CLEAR = 2'b10,
        CMD_LOAD  = 2'b11
    } cmd_e;

    state_e        state;
    state_e        state_next;
    logic [PW-1:0] presc;
    logic [PW-1:0] presc_next;
    logic [CW-1:0] target;
    logic [CW-1:0] target_next;
    logic [CW-1:0] count_next;
    logic [CW-1:0] count_inc;
    logic          ready;
    logic          ready_next;
    logic          running_next;
    logic          alarm_next;
    logic          overflow_next;
    logic          err_next;
    logic          accept;
    logic          wrap;
    logic          data_is_bcd;

    assign cmd_bus.cmd_ready = ready;
    assign accept = cmd_bus.cmd_valid & ready;

    // Digit 0 is enabled on the last prescaler cycle while running.
    assign tick = (state == RUN) && (presc == PW'(PRESCALE - 1));

    // Ripple-enable cascade: each digit advances when all lower digits are 9.
    always_comb begin
        logic       carry;
        logic [3:0] digit;
        count_inc = count;
        carry     = tick;
        digit     = 4'd0;
        for (int i = 0; i < int'(DIGITS); i++) begin
            digit = count[4*i +: 4];
            if (carry) begin
                count_inc[4*i +: 4] = (digit == 4'd9) ? 4'd0 : digit + 4'd1;
            end
            carry = carry && (digit == 4'd9);
        end
        // Carry surviving the top digit means every digit was 9 on a tick.
        wrap = carry;
    end

    // LOAD_TARGET payload must have every nibble in 0..9.
    always_comb begin
        data_is_bcd = 1'b1;
        for (int i = 0; i < int'(DIGITS); i++) begin
            if (cmd_bus.cmd_data[4*i +: 4] > 4'd9) begin
                data_is_bcd = 1'b0;
            end
        end
    end

    // Next-state and register-input decode.
    always_comb begin
        state_next    = state;
        presc_next    = presc;
        count_next    = count;
        target_next   = target;
        ready_next    = ~accept;
        overflow_next = 1'b0;
        err_next      = 1'b0;

        // Free-running behaviour in RUN; an accepted command below may override it.
        if (state == RUN) begin
            if (tick) begin
                presc_next    = '0;
                count_next    = count_inc;
                overflow_next = wrap;
                if ((target != '0) && (count_inc == target)) begin
                    state_next = DONE;
                end
            end else begin
                presc_next = presc + PW'(1);
            end
        end

        if (accept) begin
            unique case (cmd_e'(cmd_bus.cmd))
                CMD_START: begin
                    if (state != RUN) begin
                        state_next = RUN;
                        presc_next = '0;
                        if (state == DONE) begin
                            count_next = '0;
                        end
                    end
                end
                CMD_STOP: begin
                    // Discard any coincident tick and freeze the prescaler.
                    if (state == RUN) begin
                        state_next    = HOLD;
                        presc_next    = presc;
                        count_next    = count;
                        overflow_next = 1'b0;
                    end
                end
                CMD_CLEAR: begin
                    state_next    = IDLE;
                    presc_next    = '0;
                    count_next    = '0;
                    overflow_next = 1'b0;
                end
                CMD_LOAD: begin
                    // Target updates after this edge, so a coincident tick
                    // still compares against the old target above.
                    if (data_is_bcd) begin
                        target_next = cmd_bus.cmd_data;
                    end else begin
                        err_next = 1'b1;
                    end
                end
                default: begin
                end
            endcase
        end

        running_next = (state_next == RUN);
        alarm_next   = (state_next == DONE);
    end

    // State and output registers.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state    <= IDLE;
            presc    <= '0;
            count    <= '0;
            target   <= '0;
            ready    <= 1'b1;
            running  <= 1'b0;
            alarm    <= 1'b0;
            overflow <= 1'b0;
            err      <= 1'b0;
        end else begin
            state    <= state_next;
            presc    <= presc_next;
            count    <= count_next;
            target   <= target_next;
            ready    <= ready_next;
            running  <= running_next;
            alarm    <= alarm_next;
            overflow <= overflow_next;
            err      <= err_next;
        end
    end
endmodule

// File: tb/tb_bcd_timer_ctrl.sv
// Directed testbench for bcd_timer_ctrl (DIGITS=4, PRESCALE=3).
// Inputs change away from the rising edge; outputs are sampled on the falling edge.
module tb_bcd_timer_ctrl;
    localparam int unsigned DIGITS   = 4;
    localparam int unsigned PRESCALE = 3;

    localparam logic [1:0] START = 2'b00;
    localparam logic [1:0] STOP  = 2'b01;
    localparam logic [1:0] CLEAR = 2'b10;
    localparam logic [1:0] LOAD  = 2'b11;

    logic        clock;
    logic        reset;
    logic [15:0] count;
    logic        running;
    logic        alarm;
    logic        tick;
    logic        overflow;
    logic        err;

    int n_checks = 0;
    int n_fail   = 0;

    bcd_timer_ctrl_if #(.DIGITS(DIGITS)) bus ();

    bcd_timer_ctrl #(
        .DIGITS   (DIGITS),
        .PRESCALE (PRESCALE)
    ) dut (
        .clock    (clock),
        .reset    (reset),
        .cmd_bus  (bus),
        .count    (count),
        .running  (running),
        .alarm    (alarm),
        .tick     (tick),
        .overflow (overflow),
        .err      (err)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    // Caller is positioned at a falling edge; returns just after the accepting edge.
    task automatic send_cmd(input logic [1:0] c, input logic [15:0] d);
        int n;
        n = 0;
        while (!bus.cmd_ready && n < 4) begin
            @(negedge clock);
            n++;
        end
        check("cmd_ready_before_send", 32'(bus.cmd_ready), 32'd1);
        bus.cmd_valid = 1'b1;
        bus.cmd       = c;
        bus.cmd_data  = d;
        @(posedge clock);
        #1;
        bus.cmd_valid = 1'b0;
    endtask

    // Returns at the falling edge of the first cycle showing value v.
    task automatic wait_count(input string tag, input logic [15:0] v, input int budget);
        int n;
        n = 0;
        @(negedge clock);
        while (count !== v && n < budget) begin
            @(negedge clock);
            n++;
        end
        check(tag, 32'(count), 32'(v));
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int n_ticks;
        reset         = 1'b1;
        bus.cmd_valid = 1'b0;
        bus.cmd       = 2'b00;
        bus.cmd_data  = 16'h0000;
        repeat (3) @(negedge clock);
        reset = 1'b0;

        // Reset state
        @(negedge clock);
        check("rst_count", 32'(count), 32'h0000);
        check("rst_running", 32'(running), 32'd0);
        check("rst_alarm", 32'(alarm), 32'd0);
        check("rst_ready", 32'(bus.cmd_ready), 32'd1);
        check("rst_tick", 32'(tick), 32'd0);
        check("rst_overflow", 32'(overflow), 32'd0);
        check("rst_err", 32'(err), 32'd0);

        // START then 30 cycles: 10 ticks, count 0010, ready low one cycle
        send_cmd(START, 16'h0000);
        n_ticks = 0;
        for (int i = 0; i < 30; i++) begin
            @(negedge clock);
            if (i == 0) check("ready_low_after_accept", 32'(bus.cmd_ready), 32'd0);
            if (i == 1) check("ready_back_high", 32'(bus.cmd_ready), 32'd1);
            if (tick) n_ticks++;
        end
        check("tick_count_30cyc", 32'(n_ticks), 32'd10);
        @(negedge clock);
        check("count_after_30cyc", 32'(count), 32'h0010);
        check("running_after_start", 32'(running), 32'd1);

        // Asynchronous reset between edges mid-run
        wait_count("reach_0042", 16'h0042, 200);
        #2;
        reset = 1'b1;
        #1;
        check("async_rst_count", 32'(count), 32'h0000);
        check("async_rst_running", 32'(running), 32'd0);
        check("async_rst_ready", 32'(bus.cmd_ready), 32'd1);
        @(negedge clock);
        reset = 1'b0;

        // Carry across digits 1-3, then full wrap with overflow
        @(negedge clock);
        send_cmd(START, 16'h0000);
        wait_count("reach_0999", 16'h0999, 4000);
        repeat (2) @(negedge clock);
        check("tick_at_0999", 32'(tick), 32'd1);
        @(negedge clock);
        check("carry_to_1000", 32'(count), 32'h1000);
        wait_count("reach_9999", 16'h9999, 30000);
        repeat (2) @(negedge clock);
        check("tick_at_9999", 32'(tick), 32'd1);
        check("no_overflow_before_wrap", 32'(overflow), 32'd0);
        @(negedge clock);
        check("wrap_count", 32'(count), 32'h0000);
        check("wrap_overflow", 32'(overflow), 32'd1);
        check("wrap_running", 32'(running), 32'd1);
        @(negedge clock);
        check("overflow_one_cycle", 32'(overflow), 32'd0);

        // Alarm at target 0005
        send_cmd(CLEAR, 16'h0000);
        @(negedge clock);
        check("clear_running", 32'(running), 32'd0);
        send_cmd(LOAD, 16'h0005);
        @(negedge clock);
        send_cmd(START, 16'h0000);
        repeat (15) @(negedge clock);
        check("pre_alarm_count", 32'(count), 32'h0004);
        check("pre_alarm_alarm", 32'(alarm), 32'd0);
        @(negedge clock);
        check("alarm_count", 32'(count), 32'h0005);
        check("alarm_set", 32'(alarm), 32'd1);
        check("alarm_running", 32'(running), 32'd0);
        repeat (6) @(negedge clock);
        check("done_count_holds", 32'(count), 32'h0005);
        send_cmd(START, 16'h0000);
        @(negedge clock);
        check("restart_count", 32'(count), 32'h0000);
        check("restart_alarm", 32'(alarm), 32'd0);
        check("restart_running", 32'(running), 32'd1);

        // STOP at 0007 holds; START resumes from prescaler 0
        @(negedge clock);
        send_cmd(CLEAR, 16'h0000);
        @(negedge clock);
        send_cmd(LOAD, 16'h0000);
        @(negedge clock);
        send_cmd(START, 16'h0000);
        wait_count("reach_0007", 16'h0007, 100);
        send_cmd(STOP, 16'h0000);
        repeat (20) @(negedge clock);
        check("hold_count", 32'(count), 32'h0007);
        check("hold_running", 32'(running), 32'd0);
        @(negedge clock);
        send_cmd(START, 16'h0000);
        @(negedge clock);
        check("resume_tick_c1", 32'(tick), 32'd0);
        @(negedge clock);
        check("resume_tick_c2", 32'(tick), 32'd0);
        @(negedge clock);
        check("resume_tick_c3", 32'(tick), 32'd1);
        check("resume_count_c3", 32'(count), 32'h0007);
        @(negedge clock);
        check("resume_count_c4", 32'(count), 32'h0008);

        // Non-BCD LOAD_TARGET: err pulse, old target still alarms
        @(negedge clock);
        send_cmd(LOAD, 16'h0010);
        @(negedge clock);
        check("no_err_valid_load", 32'(err), 32'd0);
        send_cmd(LOAD, 16'h00A3);
        @(negedge clock);
        check("err_pulse", 32'(err), 32'd1);
        @(negedge clock);
        check("err_one_cycle", 32'(err), 32'd0);
        wait_count("reach_old_target", 16'h0010, 100);
        check("old_target_alarm", 32'(alarm), 32'd1);
        check("old_target_running", 32'(running), 32'd0);

        // CLEAR coincident with tick: increment discarded
        @(negedge clock);
        send_cmd(START, 16'h0000);
        repeat (3) @(negedge clock);
        check("tick_before_clear", 32'(tick), 32'd1);
        send_cmd(CLEAR, 16'h0000);
        @(negedge clock);
        check("clear_on_tick_count", 32'(count), 32'h0000);
        check("clear_on_tick_running", 32'(running), 32'd0);

        // LOAD_TARGET coincident with tick: increment kept, old target compared
        @(negedge clock);
        send_cmd(LOAD, 16'h0001);
        @(negedge clock);
        send_cmd(START, 16'h0000);
        repeat (3) @(negedge clock);
        check("tick_before_load", 32'(tick), 32'd1);
        send_cmd(LOAD, 16'h0005);
        @(negedge clock);
        check("load_on_tick_count", 32'(count), 32'h0001);
        check("load_on_tick_alarm", 32'(alarm), 32'd1);
        send_cmd(START, 16'h0000);
        wait_count("reach_new_target", 16'h0005, 100);
        check("new_target_alarm", 32'(alarm), 32'd1);

        // STOP coincident with tick: increment discarded
        @(negedge clock);
        send_cmd(START, 16'h0000);
        repeat (3) @(negedge clock);
        check("tick_before_stop", 32'(tick), 32'd1);
        send_cmd(STOP, 16'h0000);
        @(negedge clock);
        check("stop_on_tick_count", 32'(count), 32'h0000);
        check("stop_on_tick_running", 32'(running), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
